// File: rtl/controle_de_busca.sv
// ============================================================================
//  Module      : controle_de_busca
//  Description : Instruction-fetch sequencer. Owns the PC, registers fetched
//                words toward decode over valid/ready, absorbs absolute
//                jumps, takes branch redirects and stops on HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_de_busca #(
  parameter logic [31:0] RESET_PC    = 32'd1,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [4:0]  JUMP_OP     = 5'd16,
  parameter logic [4:0]  HALT_OP     = 5'd18
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] endereco,
  input  logic [31:0] instrucao,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int CNT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INIT_LAST =
    CNT_W'((INIT_CYCLES > 0) ? (INIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      pc, pc_nx;
  logic [CNT_W-1:0] init_cnt, init_cnt_nx;
  logic [31:0]      instr_out_nx, pc_out_nx, fetch_count_nx;
  logic             instr_valid_nx, halted_nx;

  logic       accept;
  logic       slot_free;
  logic [4:0] opcode;

  assign endereco  = pc;
  assign accept    = instr_valid & instr_ready;
  assign slot_free = ~instr_valid | instr_ready;
  assign opcode    = instrucao[31:27];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      pc          <= RESET_PC;
      init_cnt    <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      init_cnt    <= init_cnt_nx;
      instr_out   <= instr_out_nx;
      pc_out      <= pc_out_nx;
      instr_valid <= instr_valid_nx;
      halted      <= halted_nx;
      fetch_count <= fetch_count_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    init_cnt_nx    = init_cnt;
    instr_out_nx   = instr_out;
    pc_out_nx      = pc_out;
    instr_valid_nx = instr_valid;
    halted_nx      = halted;
    fetch_count_nx = fetch_count + {31'd0, accept};

    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          init_cnt_nx = '0;
          state_nx    = ST_FETCH;
        end else begin
          init_cnt_nx = init_cnt + 1'b1;
        end
      end

      ST_FETCH: begin
        if (slot_free) begin
          if (opcode == JUMP_OP) begin
            // Jump is resolved here and never reaches decode.
            pc_nx          = {5'b0, instrucao[26:0]};
            instr_valid_nx = 1'b0;
          end else if (opcode == HALT_OP) begin
            instr_out_nx   = instrucao;
            pc_out_nx      = pc;
            instr_valid_nx = 1'b1;
            state_nx       = ST_DRAIN;
          end else begin
            instr_out_nx   = instrucao;
            pc_out_nx      = pc;
            instr_valid_nx = 1'b1;
            pc_nx          = pc + 32'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (accept) begin
          instr_valid_nx = 1'b0;
          halted_nx      = 1'b1;
          state_nx       = ST_HALTED;
        end
      end

      ST_HALTED: begin
      end

      default: state_nx = ST_INIT;
    endcase

    // A taken branch wins over anything decided above, including a stall.
    if (redirect && (state == ST_FETCH || state == ST_DRAIN)) begin
      pc_nx          = redirect_pc;
      instr_valid_nx = 1'b0;
      halted_nx      = halted;
      state_nx       = ST_FETCH;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_controle_de_busca.sv
// ============================================================================
//  Module      : tb_controle_de_busca
//  Description : Self-checking bench for controle_de_busca with a scoreboard
//                of expected accepted words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_de_busca;

  logic        clock;
  logic        reset;
  logic [31:0] endereco;
  logic [31:0] instrucao;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] fetch_count;

  controle_de_busca dut (
    .clock       (clock),
    .reset       (reset),
    .endereco    (endereco),
    .instrucao   (instrucao),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:255];
  assign instrucao = (endereco < 32'd256) ? mem[endereco[7:0]] : 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] HALT_WORD = {5'd18, 27'd0};
  localparam logic [31:0] X_WORD    = 32'h0ABC_DEF0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input int i);
    return {5'd1, 27'(i * 3 + 7)};
  endfunction

  function automatic logic [31:0] jmp(input int t);
    return {5'd16, 27'(t)};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = dflt(i);
  endtask

  task automatic push(input int p);
    exp_t e;
    e.pc  = 32'(p);
    e.ins = mem[p];
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves reset asserted; caller prepares memory/scoreboard, then releases.
  task automatic do_reset(input string tag);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    check({tag, "_rst_valid"},  {31'd0, instr_valid}, 32'd0);
    check({tag, "_rst_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_rst_count"},  fetch_count, 32'd0);
    check({tag, "_rst_iout"},   instr_out, 32'd0);
    check({tag, "_rst_pcout"},  pc_out, 32'd0);
    check({tag, "_rst_addr"},   endereco, 32'd1);
    sb.delete();
    init_mem();
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] p, input int max);
    for (int n = 0; n < max; n++) begin
      tick();
      if (instr_valid && pc_out == p) break;
    end
    check({tag, "_reach_pc"},    pc_out, p);
    check({tag, "_reach_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  // Scoreboard: every handshake must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) begin
      check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc",    pc_out, e.pc);
        check("sb_instr", instr_out, e.ins);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    init_mem();

    // 1: startup latency and streaming
    do_reset("t1");
    instr_ready = 1'b1;
    push(1); push(2); push(3);
    reset = 1'b0;
    tick(); check("t1_init0", {31'd0, instr_valid}, 32'd0);
    tick(); check("t1_init1", {31'd0, instr_valid}, 32'd0);
    tick(); check("t1_first_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_pc1", pc_out, 32'd1);
    check("t1_ins1", instr_out, dflt(1));
    tick(); check("t1_pc2", pc_out, 32'd2);
    tick(); check("t1_pc3", pc_out, 32'd3);
    tick(); instr_ready = 1'b0;
    check("t1_count", fetch_count, 32'd3);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // 2: absolute jump costs one bubble
    do_reset("t2");
    mem[1] = jmp(68); mem[68] = X_WORD;
    instr_ready = 1'b1;
    push(68);
    reset = 1'b0;
    tick(); tick();
    tick(); check("t2_bubble", {31'd0, instr_valid}, 32'd0);
    check("t2_addr68", endereco, 32'd68);
    tick(); check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_pc68", pc_out, 32'd68);
    check("t2_insX", instr_out, X_WORD);
    tick(); instr_ready = 1'b0;
    check("t2_count", fetch_count, 32'd1);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: stall holds the word
    do_reset("t3");
    instr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(i);
    reset = 1'b0;
    wait_pc("t3", 32'd5, 20);
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_stall_pc", pc_out, 32'd5);
      check("t3_stall_ins", instr_out, dflt(5));
      check("t3_stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    tick(); check("t3_pc6", pc_out, 32'd6);
    tick(); tick(); tick();
    instr_ready = 1'b0;
    check("t3_count", fetch_count, 32'd8);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: redirect flushes a stalled word
    do_reset("t4");
    instr_ready = 1'b1;
    for (int i = 1; i <= 11; i++) push(i);
    reset = 1'b0;
    wait_pc("t4", 32'd12, 30);
    instr_ready = 1'b0;
    tick(); check("t4_stalled", pc_out, 32'd12);
    redirect = 1'b1; redirect_pc = 32'd33;
    tick(); redirect = 1'b0;
    check("t4_flush", {31'd0, instr_valid}, 32'd0);
    check("t4_addr33", endereco, 32'd33);
    check("t4_count_drop", fetch_count, 32'd11);
    push(33); push(34);
    instr_ready = 1'b1;
    tick(); check("t4_valid33", {31'd0, instr_valid}, 32'd1);
    check("t4_pc33", pc_out, 32'd33);
    check("t4_ins33", instr_out, dflt(33));
    tick(); tick(); instr_ready = 1'b0;
    check("t4_count", fetch_count, 32'd13);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: HALT drains then stops fetching
    do_reset("t5");
    mem[1] = jmp(88); mem[90] = HALT_WORD;
    instr_ready = 1'b1;
    push(88); push(89); push(90);
    reset = 1'b0;
    wait_pc("t5", 32'd90, 30);
    instr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t5_hold_valid", {31'd0, instr_valid}, 32'd1);
      check("t5_hold_ins", instr_out, HALT_WORD);
      check("t5_hold_halted", {31'd0, halted}, 32'd0);
      check("t5_hold_addr", endereco, 32'd90);
    end
    instr_ready = 1'b1;
    tick();
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_valid0", {31'd0, instr_valid}, 32'd0);
    check("t5_count", fetch_count, 32'd3);
    redirect = 1'b1; redirect_pc = 32'd5;
    tick(); redirect = 1'b0;
    check("t5_redir_ignored", endereco, 32'd90);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_stop_addr", endereco, 32'd90);
      check("t5_stop_halted", {31'd0, halted}, 32'd1);
      check("t5_stop_valid", {31'd0, instr_valid}, 32'd0);
    end
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset mid-stream
    do_reset("t6");
    mem[1] = jmp(38);
    instr_ready = 1'b1;
    push(38); push(39);
    reset = 1'b0;
    wait_pc("t6", 32'd40, 30);
    reset = 1'b1;
    tick();
    check("t6_valid0", {31'd0, instr_valid}, 32'd0);
    check("t6_halted0", {31'd0, halted}, 32'd0);
    check("t6_count0", fetch_count, 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    mem[1] = dflt(1);
    push(1);
    reset = 1'b0;
    tick(); check("t6_init0", {31'd0, instr_valid}, 32'd0);
    tick(); check("t6_init1", {31'd0, instr_valid}, 32'd0);
    tick(); check("t6_restart_pc", pc_out, 32'd1);
    check("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
    tick(); instr_ready = 1'b0;
    check("t6_count", fetch_count, 32'd1);
    check("t6_sb_done", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
